// File: rtl/vga_plot_arbiter.sv
// rtl/vga_plot_arbiter.sv - round-robin arbiter sharing the VGA adapter pixel port
// Grants one drawing engine at a time, caps bursts, clips off-screen pixels, registers adapter outputs.
module vga_plot_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [8*NUM_REQ-1:0]   pix_x,
  input  logic [7*NUM_REQ-1:0]   pix_y,
  input  logic [3*NUM_REQ-1:0]   pix_colour,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   clipped,
  output logic                   busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0]    owner_q, owner_d;
  logic [IDXW-1:0]    rr_q, rr_d;
  logic [15:0]        burst_q, burst_d;
  logic [7:0]         vx_q, vx_d;
  logic [6:0]         vy_q, vy_d;
  logic [2:0]         vc_q, vc_d;
  logic               plot_q, plot_d;
  logic               clip_q, clip_d;

  logic [IDXW-1:0]    win;
  logic [7:0]         cur_x;
  logic [6:0]         cur_y;
  logic [2:0]         cur_c;
  logic               accept;
  logic               others;
  logic [15:0]        burst_next;
  logic               hit_cap;
  logic               release_grant;

  // First requester at or after rr_q, scanning upward modulo NUM_REQ.
  always_comb begin
    int idx;
    logic found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDXW'(idx);
      end
    end
  end

  always_comb begin
    cur_x         = pix_x[8*int'(owner_q) +: 8];
    cur_y         = pix_y[7*int'(owner_q) +: 7];
    cur_c         = pix_colour[3*int'(owner_q) +: 3];
    accept        = (state_q == GRANT) && gnt_q[owner_q] && pix_valid[owner_q];
    others        = |(req & ~gnt_q);
    burst_next    = (burst_q == 16'hFFFF) ? burst_q : burst_q + 16'd1;
    hit_cap       = accept && (burst_next == 16'(MAX_BURST));
    release_grant = !req[owner_q] || (hit_cap && others);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    clip_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = GRANT;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          rr_d         = (int'(win) == NUM_REQ - 1) ? '0 : IDXW'(int'(win) + 1);
          burst_d      = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          // A full burst with nobody waiting just restarts the count.
          burst_d = (hit_cap && !others) ? 16'd0 : burst_next;
          if (cur_x < 8'd160 && cur_y < 7'd120) begin
            vx_d   = cur_x;
            vy_d   = cur_y;
            vc_d   = cur_c;
            plot_d = 1'b1;
          end else begin
            clip_d = 1'b1;
          end
        end
        if (release_grant) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      clip_q  <= clip_d;
    end
  end

  assign gnt        = gnt_q;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;
  assign clipped    = clip_q;
  assign busy       = (state_q == GRANT);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb/tb_vga_plot_arbiter.sv - directed vector bench for vga_plot_arbiter
// Three requesters, burst cap of 4.
module tb_vga_plot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  pix_valid;
  logic [23:0] pix_x;
  logic [20:0] pix_y;
  logic [8:0]  pix_colour;
  logic [2:0]  gnt;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clipped;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  vga_plot_arbiter #(.NUM_REQ(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .clipped(clipped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] vld;
    int         idx;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [2:0] e_gnt;
    logic       e_plot;
    logic       e_clip;
    logic       e_busy;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic [2:0] rq, input logic [2:0] vl,
                       input int idx, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    rst_n      = r;
    req        = rq;
    pix_valid  = vl;
    pix_x      = '0;
    pix_y      = '0;
    pix_colour = '0;
    pix_x[8*idx +: 8]      = x;
    pix_y[7*idx +: 7]      = y;
    pix_colour[3*idx +: 3] = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic [2:0] rq, logic [2:0] vl, int idx,
                              logic [7:0] x, logic [6:0] y, logic [2:0] c,
                              logic [2:0] eg, logic ep, logic ec, logic eb,
                              logic [7:0] ex, logic [6:0] ey, logic [2:0] ecol);
    vec_t v;
    v.rst_n = r; v.req = rq; v.vld = vl; v.idx = idx; v.x = x; v.y = y; v.c = c;
    v.e_gnt = eg; v.e_plot = ep; v.e_clip = ec; v.e_busy = eb;
    v.e_x = ex; v.e_y = ey; v.e_c = ecol;
    return v;
  endfunction

  initial begin
    int order[4];
    int plots;
    order = '{0, 1, 2, 0};
    drive(1'b0, 3'b000, 3'b000, 0, 8'd0, 7'd0, 3'd0);

    // reset, single requester, clipping, non-owner isolation, valid with req low
    vecs.push_back(mk(0, 3'b000, 3'b000, 0,   0,   0, 0, 3'b000, 0, 0, 0,   0,   0, 0));
    vecs.push_back(mk(1, 3'b010, 3'b000, 1,   0,   0, 0, 3'b010, 0, 0, 1,   0,   0, 0));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1,  10,  20, 2, 3'b010, 1, 0, 1,  10,  20, 2));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1,  11,  20, 2, 3'b010, 1, 0, 1,  11,  20, 2));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1,  12,  20, 2, 3'b010, 1, 0, 1,  12,  20, 2));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1,  13,  20, 2, 3'b010, 1, 0, 1,  13,  20, 2));
    vecs.push_back(mk(1, 3'b000, 3'b000, 1,   0,   0, 0, 3'b000, 0, 0, 0,  13,  20, 2));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0,   0,   0, 0, 3'b001, 0, 0, 1,  13,  20, 2));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 159, 119, 5, 3'b001, 1, 0, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 160,   5, 3, 3'b001, 0, 1, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b001, 3'b001, 0,  10, 120, 1, 3'b001, 0, 1, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b001, 3'b000, 0,   0,   0, 0, 3'b001, 0, 0, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b011, 3'b010, 1,  50,  50, 4, 3'b001, 0, 0, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b001, 3'b010, 1,  50,  50, 4, 3'b001, 0, 0, 1, 159, 119, 5));
    vecs.push_back(mk(1, 3'b000, 3'b001, 0,   1,   2, 7, 3'b000, 1, 0, 0,   1,   2, 7));
    vecs.push_back(mk(1, 3'b000, 3'b001, 0,   1,   2, 7, 3'b000, 0, 0, 0,   1,   2, 7));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].req, vecs[i].vld, vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].c);
      tick();
      check($sformatf("v%0d gnt", i),    int'(gnt),        int'(vecs[i].e_gnt));
      check($sformatf("v%0d plot", i),   int'(vga_plot),   int'(vecs[i].e_plot));
      check($sformatf("v%0d clip", i),   int'(clipped),    int'(vecs[i].e_clip));
      check($sformatf("v%0d busy", i),   int'(busy),       int'(vecs[i].e_busy));
      check($sformatf("v%0d vga_x", i),  int'(vga_x),      int'(vecs[i].e_x));
      check($sformatf("v%0d vga_y", i),  int'(vga_y),      int'(vecs[i].e_y));
      check($sformatf("v%0d colour", i), int'(vga_colour), int'(vecs[i].e_c));
    end

    // burst cap with no contender: rr_ptr now 1, so requester 2 wins and keeps the grant
    drive(1, 3'b100, 3'b000, 2, 0, 0, 0);
    tick();
    check("cap grant", int'(gnt), 3'b100);
    plots = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'b100, 3'b100, 2, 8'(60 + i), 7'd10, 3'd1);
      tick();
      check($sformatf("cap%0d gnt", i), int'(gnt), 3'b100);
      check($sformatf("cap%0d x", i), int'(vga_x), 60 + i);
      if (vga_plot) plots++;
    end
    check("cap plots", plots, 10);
    drive(1, 3'b000, 3'b000, 2, 0, 0, 0);
    tick();
    check("cap release", int'(gnt), 0);

    // round robin: all request and present every cycle; x identifies the source
    rst_n = 1; req = 3'b111; pix_valid = 3'b111;
    pix_x = {8'd32, 8'd31, 8'd30}; pix_y = {7'd3, 7'd2, 7'd1}; pix_colour = 9'o765;
    for (int k = 0; k < 17; k++) begin
      tick();
      check($sformatf("rr%0d gnt", k), int'(gnt), (k % 5 == 4) ? 0 : (1 << order[k / 5]));
      check($sformatf("rr%0d plot", k), int'(vga_plot), (k % 5 != 0) ? 1 : 0);
      if (k % 5 != 0) check($sformatf("rr%0d x", k), int'(vga_x), 30 + order[(k - 1) / 5]);
    end

    // reset mid-burst during a grant to requester 1
    drive(1, 3'b000, 3'b000, 0, 0, 0, 0);
    tick();
    check("pre-rst release", int'(gnt), 0);
    drive(1, 3'b010, 3'b000, 1, 0, 0, 0);
    tick();
    check("pre-rst grant", int'(gnt), 3'b010);
    drive(1, 3'b010, 3'b010, 1, 40, 41, 6);
    tick();
    check("pre-rst plot", int'(vga_plot), 1);
    check("pre-rst x", int'(vga_x), 40);
    drive(0, 3'b010, 3'b010, 1, 42, 43, 5);
    tick();
    check("rst gnt", int'(gnt), 0);
    check("rst plot", int'(vga_plot), 0);
    check("rst busy", int'(busy), 0);
    check("rst x", int'(vga_x), 0);
    check("rst y", int'(vga_y), 0);
    check("rst colour", int'(vga_colour), 0);
    drive(1, 3'b011, 3'b000, 0, 0, 0, 0);
    tick();
    check("post-rst grant", int'(gnt), 3'b001);
    check("post-rst busy", int'(busy), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
